// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding word
// read at a time, and buffers returned words with their PC in a small FIFO
// that decode drains with valid/ready. A redirect flushes everything and
// restarts fetch at the new target.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        state, state_next;
    logic [31:0]   fpc, fpc_next;
    logic [31:0]   req_addr, req_addr_next;
    logic [CW-1:0] count, count_next, count_push;
    logic [AW-1:0] rd_ptr, wr_ptr;
    entry_t        store [DEPTH];
    logic          push, pop, flush;
    logic [31:0]   target;

    // Redirect targets are always word aligned.
    assign target = redirect_pc & 32'hFFFF_FFFC;

    // Decode-side handshake; a redirect cancels the pop in the same cycle.
    assign pop = (count != '0) && inst_ready && !redirect;

    // Occupancy after a push this cycle (decides whether to keep fetching).
    assign count_push = count + CW'(1) - CW'(pop);

    // Next-state and fetch-PC logic.
    always_comb begin
        state_next    = state;
        fpc_next      = fpc;
        req_addr_next = req_addr;
        push          = 1'b0;
        flush         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fpc_next = target;
                    flush    = 1'b1;
                end else if (count < DEPTH_C) begin
                    req_addr_next = fpc;
                    state_next    = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fpc_next   = target;
                        flush      = 1'b1;
                        state_next = IDLE;
                    end else begin
                        push     = 1'b1;
                        fpc_next = fpc + PC_STEP;
                        if (count_push < DEPTH_C) begin
                            req_addr_next = fpc + PC_STEP;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end else if (redirect) begin
                    fpc_next   = target;
                    flush      = 1'b1;
                    state_next = DROP;
                end
            end
            DROP: begin
                if (redirect) begin
                    fpc_next = target;
                    flush    = 1'b1;
                end
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO occupancy update; flush wins over any push or pop.
    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
        if (flush) begin
            count_next = '0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            fpc      <= fpc_next;
            req_addr <= req_addr_next;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // FIFO storage: each entry holds the fetched word and its PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[AW'(i)] <= '0;
            end
        end else if (push) begin
            store[wr_ptr] <= '{pc: fpc, word: imem_rdata};
        end
    end

    assign imem_req   = (state != IDLE);
    assign imem_addr  = req_addr;
    assign inst_valid = (count != '0);
    assign inst       = store[rd_ptr].word;
    assign inst_pc    = store[rd_ptr].pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run scored against a transaction-level model (expected PC stream + queue).
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks = 0;
    int passed = 0;
    int lat_cnt = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory responder: ack on the lat-th cycle of a request.
    task automatic drive_mem(input int lat);
        if (imem_req) begin
            if (lat_cnt + 1 >= lat) begin
                imem_ack = 1'b1;
                lat_cnt  = 0;
            end else begin
                imem_ack = 1'b0;
                lat_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            lat_cnt  = 0;
        end
    endtask

    // Hold reset for two cycles; returns at a falling edge with rst still low.
    task automatic start();
        @(negedge clk);
        rst         = 1'b0;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat_cnt     = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        start();
        checks++;
        if ({imem_req, inst_valid} !== 2'b00) $display("FAIL reset_req_valid got=%b exp=00", {imem_req, inst_valid});
        else passed++;
        checks++;
        if (imem_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=00000000", imem_addr);
        else passed++;
        checks++;
        if ({inst, inst_pc} !== 64'h0) $display("FAIL reset_head got=%h/%h exp=0/0", inst, inst_pc);
        else passed++;
        rst = 1'b1;
    endtask

    // Zero-wait memory: one request per cycle, first instruction on cycle 2.
    task automatic test_stream();
        logic [31:0] a;
        start();
        inst_ready = 1'b1;
        imem_ack   = 1'b1;
        rst        = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            a = 32'(4 * (k - 1));
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, a}) $display("FAIL stream_addr k=%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, a);
            else passed++;
            a = 32'(4 * (k - 2));
            checks++;
            if (k == 1) begin
                if (inst_valid !== 1'b0) $display("FAIL stream_valid0 got=%b exp=0", inst_valid);
                else passed++;
            end else begin
                if ({inst_valid, inst_pc, inst} !== {1'b1, a, mem_word(a)})
                    $display("FAIL stream_inst k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst, a, mem_word(a));
                else passed++;
            end
        end
    endtask

    // Decode stalled: FIFO fills with exactly DEPTH entries, then drains gap-free.
    task automatic test_full();
        int acks = 0;
        logic [31:0] e = 32'h0;
        start();
        imem_ack = 1'b1;
        rst      = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (imem_req && imem_ack) acks++;
            if (k >= 2) begin
                checks++;
                if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) $display("FAIL full_head k=%0d got=%b/%h exp=1/0", k, inst_valid, inst_pc);
                else passed++;
            end
            if (k >= 5) begin
                checks++;
                if (imem_req !== 1'b0) $display("FAIL full_req_low k=%0d got=%b exp=0", k, imem_req);
                else passed++;
            end
        end
        checks++;
        if (acks != 4) $display("FAIL full_pushes got=%0d exp=4", acks);
        else passed++;
        inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, e, mem_word(e)})
                $display("FAIL drain i=%0d got=%b/%h/%h exp=1/%h/%h", i, inst_valid, inst_pc, inst, e, mem_word(e));
            else passed++;
            e = e + 32'd4;
            tick();
        end
    endtask

    // Redirect while a slow request is pending: address held, data dropped.
    task automatic test_redirect_pending();
        bit found = 0, stale_ack = 0, new_req = 0, got = 0;
        start();
        inst_ready = 1'b1;
        rst        = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            drive_mem(3);
            if (imem_req && imem_addr == 32'h8 && !imem_ack) found = 1;
        end
        checks++;
        if (!found) $display("FAIL pend_setup got=timeout exp=req_at_8");
        else passed++;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            redirect = 1'b0;
            if (inst_valid) begin
                checks++;
                if ({inst_pc, inst} !== {32'h40, mem_word(32'h40)})
                    $display("FAIL pend_first_inst got=%h/%h exp=00000040/%h", inst_pc, inst, mem_word(32'h40));
                else passed++;
                got = 1;
            end
            if (!stale_ack) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, 32'h8}) $display("FAIL pend_hold got=%b/%h exp=1/00000008", imem_req, imem_addr);
                else passed++;
            end else if (!new_req && imem_req) begin
                checks++;
                if (imem_addr !== 32'h40) $display("FAIL pend_new_addr got=%h exp=00000040", imem_addr);
                else passed++;
                new_req = 1;
            end
            drive_mem(3);
            if (!stale_ack && imem_ack) stale_ack = 1;
        end
        checks++;
        if (!(got && new_req)) $display("FAIL pend_progress got=%0d%0d exp=11", got, new_req);
        else passed++;
    endtask

    // Redirect racing pop/ack, and two redirects while draining a stale read.
    task automatic test_redirect_corner();
        start();
        imem_ack = 1'b1;
        rst      = 1'b1;
        repeat (8) tick();
        checks++;
        if ({imem_req, inst_valid, inst_pc} !== {2'b01, 32'h0}) $display("FAIL corner_full got=%b%b/%h exp=01/0", imem_req, inst_valid, inst_pc);
        else passed++;
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        checks++;
        if ({imem_req, inst_valid} !== 2'b00) $display("FAIL corner_flush_full got=%b%b exp=00", imem_req, inst_valid);
        else passed++;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) $display("FAIL corner_req100 got=%b/%h exp=1/00000100", imem_req, imem_addr);
        else passed++;
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, mem_word(32'h100)}) $display("FAIL corner_inst100 got=%b/%h/%h exp=1/00000100/%h", inst_valid, inst_pc, inst, mem_word(32'h100));
        else passed++;
        // Redirect together with ack and pop.
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        checks++;
        if ({imem_req, inst_valid} !== 2'b00) $display("FAIL corner_flush_ack got=%b%b exp=00", imem_req, inst_valid);
        else passed++;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) $display("FAIL corner_req200 got=%b/%h exp=1/00000200", imem_req, imem_addr);
        else passed++;
        // Pending read at 0x200, then two redirects before its ack.
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h400;
        checks++;
        if ({imem_req, inst_valid, imem_addr} !== {2'b10, 32'h200}) $display("FAIL corner_drop1 got=%b%b/%h exp=10/00000200", imem_req, inst_valid, imem_addr);
        else passed++;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) $display("FAIL corner_drop2 got=%b/%h exp=1/00000200", imem_req, imem_addr);
        else passed++;
        tick();
        checks++;
        if ({imem_req, inst_valid} !== 2'b00) $display("FAIL corner_drop_done got=%b%b exp=00", imem_req, inst_valid);
        else passed++;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h400}) $display("FAIL corner_req400 got=%b/%h exp=1/00000400", imem_req, imem_addr);
        else passed++;
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h400, mem_word(32'h400)}) $display("FAIL corner_inst400 got=%b/%h/%h exp=1/00000400/%h", inst_valid, inst_pc, inst, mem_word(32'h400));
        else passed++;
    endtask

    // Reset asserted between clock edges during a pending read.
    task automatic test_async_reset();
        bit found = 0;
        start();
        rst = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            drive_mem(3);
            if (imem_req && !imem_ack && inst_valid) found = 1;
        end
        checks++;
        if (!found) $display("FAIL areset_setup got=timeout exp=pending_with_data");
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, inst_valid, imem_addr} !== {2'b00, 32'h0}) $display("FAIL areset_now got=%b%b/%h exp=00/00000000", imem_req, inst_valid, imem_addr);
        else passed++;
        checks++;
        if ({inst, inst_pc} !== 64'h0) $display("FAIL areset_head got=%h/%h exp=0/0", inst, inst_pc);
        else passed++;
        tick();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL areset_restart got=%b/%h exp=1/00000000", imem_req, imem_addr);
        else passed++;
        tick();
        checks++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) $display("FAIL areset_inst got=%b/%h exp=1/00000000", inst_valid, inst_pc);
        else passed++;
    endtask

    // Unaligned redirect near the top of the address space wraps to zero.
    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        int idx = 0;
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        start();
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        rst        = 1'b1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFB;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            if (inst_valid) begin
                checks++;
                if ({inst_pc, inst} !== {exp_pc[idx], mem_word(exp_pc[idx])})
                    $display("FAIL wrap_pc idx=%0d got=%h/%h exp=%h/%h", idx, inst_pc, inst, exp_pc[idx], mem_word(exp_pc[idx]));
                else passed++;
                idx++;
            end
            tick();
        end
        checks++;
        if (idx != 3) $display("FAIL wrap_count got=%0d exp=3", idx);
        else passed++;
    endtask

    // Random traffic against a stream-level model of the fetch front end.
    task automatic test_random();
        entry_t      q [$];
        logic [31:0] mfpc = 32'h0;
        logic [31:0] out_addr = 32'h0;
        bit          out_active = 0, out_live = 0, acc;
        int          pops = 0;
        entry_t      e;
        start();
        rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            checks++;
            if (inst_valid !== (q.size() != 0)) $display("FAIL rnd_valid cyc=%0d got=%b exp=%0d", cyc, inst_valid, q.size() != 0);
            else passed++;
            if (q.size() != 0) begin
                checks++;
                if ({inst_pc, inst} !== {q[0].pc, q[0].word}) $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_pc, inst, q[0].pc, q[0].word);
                else passed++;
            end
            if (out_active) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, out_addr}) $display("FAIL rnd_hold cyc=%0d got=%b/%h exp=1/%h", cyc, imem_req, imem_addr, out_addr);
                else passed++;
            end else if (imem_req) begin
                checks++;
                if (imem_addr !== mfpc) $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, mfpc);
                else passed++;
                checks++;
                if (q.size() >= DEPTH) $display("FAIL rnd_req_room cyc=%0d got=%0d exp<%0d", cyc, q.size(), DEPTH);
                else passed++;
                out_active = 1;
                out_live   = 1;
                out_addr   = mfpc;
            end
            imem_ack    = ($urandom_range(0, 2) != 0);
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 1) == 0) ? 32'($urandom) : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
            acc = imem_req && imem_ack;
            if (redirect) begin
                q.delete();
                mfpc = redirect_pc & 32'hFFFF_FFFC;
                if (out_active) begin
                    if (acc) out_active = 0;
                    else out_live = 0;
                end
            end else begin
                if (q.size() != 0 && inst_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
                if (out_active && acc) begin
                    if (out_live) begin
                        e.pc   = mfpc;
                        e.word = mem_word(mfpc);
                        q.push_back(e);
                        mfpc = mfpc + 32'd4;
                    end
                    out_active = 0;
                end
            end
        end
        redirect = 1'b0;
        checks++;
        if (pops < 500) $display("FAIL rnd_progress got=%0d exp>=500", pops);
        else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_pending();
        test_redirect_corner();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
